// File: rtl/counter_shiftreg_unit.sv
// -----------------------------------------------------------------------------
// counter_shiftreg_unit
//
// Two independent sequential elements sharing one clock and one asynchronous
// active-low reset:
//   * a CNT_WIDTH-bit binary up-counter with enable and synchronous clear
//   * a SR_WIDTH-bit parallel-load, serial-in/serial-out shift register whose
//     shift direction is fixed by the DIRECTION parameter
//
// Parameters:
//   CNT_WIDTH   counter width in bits
//   SR_WIDTH    shift register width in bits (must be >= 2)
//   DIRECTION   1 = shift toward MSB (left), 0 = shift toward LSB (right)
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   clrn         asynchronous active-low reset, clears both elements
//   cnt_sclr     counter synchronous clear, active-low (beats cnt_en)
//   cnt_en       counter count enable, active-high
//   cnt_q        counter value
//   sr_en        shift register enable, gates both load and shift
//   sr_load      parallel load request (beats shift)
//   sr_data      parallel load data
//   sr_shiftin   serial input bit
//   sr_sclr      shift register synchronous clear, active-low (beats all)
//   sr_q         shift register contents
//   sr_shiftout  serial output: the bit that leaves on the next shift
// -----------------------------------------------------------------------------
module counter_shiftreg_unit #(
   parameter int unsigned CNT_WIDTH = 8,
   parameter int unsigned SR_WIDTH  = 8,
   parameter int unsigned DIRECTION = 1
) (
   input  logic                 clk,
   input  logic                 clrn,
   input  logic                 cnt_sclr,
   input  logic                 cnt_en,
   output logic [CNT_WIDTH-1:0] cnt_q,
   input  logic                 sr_en,
   input  logic                 sr_load,
   input  logic [SR_WIDTH-1:0]  sr_data,
   input  logic                 sr_shiftin,
   input  logic                 sr_sclr,
   output logic [SR_WIDTH-1:0]  sr_q,
   output logic                 sr_shiftout
);

   logic [CNT_WIDTH-1:0] cnt_r;
   logic [SR_WIDTH-1:0]  sr_r;
   logic [SR_WIDTH-1:0]  sr_shifted;

   // ---------------------------------------------------------------------------
   // Counter: clear > enable > hold; wraps modulo 2^CNT_WIDTH, no carry out.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cnt_r <= '0;
      end else if (!cnt_sclr) begin
         cnt_r <= '0;
      end else if (cnt_en) begin
         cnt_r <= cnt_r + CNT_WIDTH'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Shift path and serial output selected at elaboration by DIRECTION.
   // The serial output is taken from the end the next shift pushes out.
   // ---------------------------------------------------------------------------
   generate
      if (DIRECTION != 0) begin : g_left
         always_comb begin
            sr_shifted  = {sr_r[SR_WIDTH-2:0], sr_shiftin};
            sr_shiftout = sr_r[SR_WIDTH-1];
         end
      end else begin : g_right
         always_comb begin
            sr_shifted  = {sr_shiftin, sr_r[SR_WIDTH-1:1]};
            sr_shiftout = sr_r[0];
         end
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Shift register: clear > (enable off: hold) > load > shift.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         sr_r <= '0;
      end else if (!sr_sclr) begin
         sr_r <= '0;
      end else if (sr_en) begin
         if (sr_load) begin
            sr_r <= sr_data;
         end else begin
            sr_r <= sr_shifted;
         end
      end
   end

   assign cnt_q = cnt_r;
   assign sr_q  = sr_r;

endmodule

// File: tb/tb_counter_shiftreg_unit.sv
// -----------------------------------------------------------------------------
// Testbench for counter_shiftreg_unit. Two instances share all inputs: one
// shifting left (DIRECTION=1) and one shifting right (DIRECTION=0).
// Inputs change 1 time unit after a rising edge and outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_counter_shiftreg_unit;

   logic       clk = 1'b0;
   logic       clrn;
   logic       cnt_sclr;
   logic       cnt_en;
   logic       sr_en;
   logic       sr_load;
   logic [7:0] sr_data;
   logic       sr_shiftin;
   logic       sr_sclr;

   logic [7:0] cnt_q_l, cnt_q_r;
   logic [7:0] sr_q_l,  sr_q_r;
   logic       so_l,    so_r;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   counter_shiftreg_unit #(.CNT_WIDTH(8), .SR_WIDTH(8), .DIRECTION(1)) dut_l (
      .clk(clk), .clrn(clrn), .cnt_sclr(cnt_sclr), .cnt_en(cnt_en), .cnt_q(cnt_q_l),
      .sr_en(sr_en), .sr_load(sr_load), .sr_data(sr_data), .sr_shiftin(sr_shiftin),
      .sr_sclr(sr_sclr), .sr_q(sr_q_l), .sr_shiftout(so_l)
   );

   counter_shiftreg_unit #(.CNT_WIDTH(8), .SR_WIDTH(8), .DIRECTION(0)) dut_r (
      .clk(clk), .clrn(clrn), .cnt_sclr(cnt_sclr), .cnt_en(cnt_en), .cnt_q(cnt_q_r),
      .sr_en(sr_en), .sr_load(sr_load), .sr_data(sr_data), .sr_shiftin(sr_shiftin),
      .sr_sclr(sr_sclr), .sr_q(sr_q_r), .sr_shiftout(so_r)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clrn = 1'b0; cnt_sclr = 1'b1; cnt_en = 1'b0;
      sr_en = 1'b0; sr_load = 1'b0; sr_data = 8'h00; sr_shiftin = 1'b0; sr_sclr = 1'b1;
      tick(); tick();
      checks++; if (cnt_q_l !== 8'h00) begin errors++; $display("FAIL reset_cnt_l got %h want 00", cnt_q_l); end
      checks++; if (cnt_q_r !== 8'h00) begin errors++; $display("FAIL reset_cnt_r got %h want 00", cnt_q_r); end
      checks++; if (sr_q_l !== 8'h00) begin errors++; $display("FAIL reset_sr_l got %h want 00", sr_q_l); end
      checks++; if (sr_q_r !== 8'h00) begin errors++; $display("FAIL reset_sr_r got %h want 00", sr_q_r); end
      checks++; if (so_l !== 1'b0) begin errors++; $display("FAIL reset_so_l got %b want 0", so_l); end
      checks++; if (so_r !== 1'b0) begin errors++; $display("FAIL reset_so_r got %b want 0", so_r); end
   endtask

   task automatic test_count();
      clrn = 1'b1; cnt_sclr = 1'b1; cnt_en = 1'b1;
      checks++; if (cnt_q_l !== 8'h00) begin errors++; $display("FAIL count_start got %h want 00", cnt_q_l); end
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (cnt_q_l !== 8'(i)) begin errors++; $display("FAIL count_step%0d got %h want %h", i, cnt_q_l, 8'(i)); end
      end
      // asynchronous clear in the middle of a cycle
      #3 clrn = 1'b0;
      #1;
      checks++; if (cnt_q_l !== 8'h00) begin errors++; $display("FAIL async_clr_cnt got %h want 00", cnt_q_l); end
      cnt_en = 1'b0;
      clrn = 1'b1;
      tick();
      checks++; if (cnt_q_l !== 8'h00) begin errors++; $display("FAIL post_clr_hold got %h want 00", cnt_q_l); end
   endtask

   task automatic test_counter_ctrl();
      cnt_en = 1'b1;
      tick(); tick(); tick();
      checks++; if (cnt_q_l !== 8'h03) begin errors++; $display("FAIL ctrl_count3 got %h want 03", cnt_q_l); end
      cnt_sclr = 1'b0;
      tick();
      checks++; if (cnt_q_l !== 8'h00) begin errors++; $display("FAIL sclr_over_en got %h want 00", cnt_q_l); end
      cnt_sclr = 1'b1;
      tick(); tick();
      checks++; if (cnt_q_l !== 8'h02) begin errors++; $display("FAIL after_sclr got %h want 02", cnt_q_l); end
      cnt_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (cnt_q_l !== 8'h02) begin errors++; $display("FAIL hold%0d got %h want 02", i, cnt_q_l); end
      end
      cnt_sclr = 1'b0;
      tick();
      cnt_sclr = 1'b1; cnt_en = 1'b1;
      for (int i = 0; i < 255; i++) tick();
      checks++; if (cnt_q_l !== 8'hFF) begin errors++; $display("FAIL preset255 got %h want ff", cnt_q_l); end
      tick();
      checks++; if (cnt_q_l !== 8'h00) begin errors++; $display("FAIL wrap got %h want 00", cnt_q_l); end
      checks++; if (cnt_q_r !== 8'h00) begin errors++; $display("FAIL wrap_r got %h want 00", cnt_q_r); end
      tick();
      checks++; if (cnt_q_l !== 8'h01) begin errors++; $display("FAIL after_wrap got %h want 01", cnt_q_l); end
      cnt_en = 1'b0;
   endtask

   task automatic test_left_fill();
      logic [7:0] ones;
      logic [7:0] exp_l;
      logic [7:0] exp_r;
      ones = 8'hFF;
      sr_sclr = 1'b0;
      tick();
      checks++; if (sr_q_l !== 8'h00) begin errors++; $display("FAIL fill_clear got %h want 00", sr_q_l); end
      sr_sclr = 1'b1; sr_en = 1'b1; sr_load = 1'b0; sr_shiftin = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp_l = ~(ones << i);
         exp_r = ~(ones >> i);
         checks++; if (sr_q_l !== exp_l) begin errors++; $display("FAIL fill_l%0d got %h want %h", i, sr_q_l, exp_l); end
         checks++; if (sr_q_r !== exp_r) begin errors++; $display("FAIL fill_r%0d got %h want %h", i, sr_q_r, exp_r); end
         checks++; if (so_l !== (i == 8)) begin errors++; $display("FAIL fill_so_l%0d got %b want %b", i, so_l, (i == 8)); end
         checks++; if (so_r !== (i == 8)) begin errors++; $display("FAIL fill_so_r%0d got %b want %b", i, so_r, (i == 8)); end
      end
   endtask

   task automatic test_load_priority();
      sr_en = 1'b1; sr_load = 1'b1; sr_data = 8'h5A; sr_shiftin = 1'b1;
      tick();
      checks++; if (sr_q_l !== 8'h5A) begin errors++; $display("FAIL load5a_l got %h want 5a", sr_q_l); end
      checks++; if (sr_q_r !== 8'h5A) begin errors++; $display("FAIL load5a_r got %h want 5a", sr_q_r); end
      sr_data = 8'hFF;
      tick();
      checks++; if (sr_q_l !== 8'hFF) begin errors++; $display("FAIL loadff got %h want ff", sr_q_l); end
      sr_sclr = 1'b0;
      tick();
      checks++; if (sr_q_l !== 8'h00) begin errors++; $display("FAIL sclr_over_load got %h want 00", sr_q_l); end
      checks++; if (sr_q_r !== 8'h00) begin errors++; $display("FAIL sclr_over_load_r got %h want 00", sr_q_r); end
      sr_sclr = 1'b1; sr_data = 8'h3C;
      tick();
      checks++; if (sr_q_l !== 8'h3C) begin errors++; $display("FAIL load3c got %h want 3c", sr_q_l); end
      sr_en = 1'b0; sr_data = 8'h00;
      tick(); tick();
      checks++; if (sr_q_l !== 8'h3C) begin errors++; $display("FAIL en_off_load got %h want 3c", sr_q_l); end
      sr_load = 1'b0;
      tick();
      checks++; if (sr_q_l !== 8'h3C) begin errors++; $display("FAIL en_off_shift_l got %h want 3c", sr_q_l); end
      checks++; if (sr_q_r !== 8'h3C) begin errors++; $display("FAIL en_off_shift_r got %h want 3c", sr_q_r); end
   endtask

   task automatic test_right_shift();
      sr_en = 1'b1; sr_load = 1'b1; sr_data = 8'h81; sr_shiftin = 1'b1;
      tick();
      checks++; if (sr_q_r !== 8'h81) begin errors++; $display("FAIL r_load got %h want 81", sr_q_r); end
      checks++; if (so_r !== 1'b1) begin errors++; $display("FAIL r_so_pre got %b want 1", so_r); end
      checks++; if (so_l !== 1'b1) begin errors++; $display("FAIL l_so_pre got %b want 1", so_l); end
      sr_load = 1'b0; sr_shiftin = 1'b0;
      tick();
      checks++; if (sr_q_r !== 8'h40) begin errors++; $display("FAIL r_shift1 got %h want 40", sr_q_r); end
      checks++; if (so_r !== 1'b0) begin errors++; $display("FAIL r_so_post got %b want 0", so_r); end
      checks++; if (sr_q_l !== 8'h02) begin errors++; $display("FAIL l_shift1 got %h want 02", sr_q_l); end
      checks++; if (so_l !== 1'b0) begin errors++; $display("FAIL l_so_post got %b want 0", so_l); end
      tick();
      checks++; if (sr_q_r !== 8'h20) begin errors++; $display("FAIL r_shift2 got %h want 20", sr_q_r); end
      checks++; if (sr_q_l !== 8'h04) begin errors++; $display("FAIL l_shift2 got %h want 04", sr_q_l); end
      sr_shiftin = 1'b1;
      tick();
      checks++; if (sr_q_r !== 8'h90) begin errors++; $display("FAIL r_shift_in1 got %h want 90", sr_q_r); end
      checks++; if (sr_q_l !== 8'h09) begin errors++; $display("FAIL l_shift_in1 got %h want 09", sr_q_l); end
   endtask

   task automatic test_independence();
      cnt_sclr = 1'b0;
      tick();
      cnt_sclr = 1'b1; cnt_en = 1'b1;
      sr_sclr = 1'b0;
      tick();
      checks++; if (cnt_q_l !== 8'h01) begin errors++; $display("FAIL ind_cnt1 got %h want 01", cnt_q_l); end
      checks++; if (sr_q_l !== 8'h00) begin errors++; $display("FAIL ind_sr_clr got %h want 00", sr_q_l); end
      sr_sclr = 1'b1; sr_load = 1'b1; sr_data = 8'hA5;
      tick();
      checks++; if (cnt_q_l !== 8'h02) begin errors++; $display("FAIL ind_cnt2 got %h want 02", cnt_q_l); end
      checks++; if (sr_q_l !== 8'hA5) begin errors++; $display("FAIL ind_sr_load got %h want a5", sr_q_l); end
      sr_load = 1'b0; sr_shiftin = 1'b0;
      tick();
      checks++; if (cnt_q_l !== 8'h03) begin errors++; $display("FAIL ind_cnt3 got %h want 03", cnt_q_l); end
      checks++; if (sr_q_l !== 8'h4A) begin errors++; $display("FAIL ind_sr_l got %h want 4a", sr_q_l); end
      checks++; if (sr_q_r !== 8'h52) begin errors++; $display("FAIL ind_sr_r got %h want 52", sr_q_r); end
      #3 clrn = 1'b0;
      #1;
      checks++; if (cnt_q_l !== 8'h00) begin errors++; $display("FAIL ind_rst_cnt got %h want 00", cnt_q_l); end
      checks++; if (sr_q_l !== 8'h00) begin errors++; $display("FAIL ind_rst_sr_l got %h want 00", sr_q_l); end
      checks++; if (sr_q_r !== 8'h00) begin errors++; $display("FAIL ind_rst_sr_r got %h want 00", sr_q_r); end
      tick();
      checks++; if (cnt_q_r !== 8'h00) begin errors++; $display("FAIL ind_rst_held got %h want 00", cnt_q_r); end
      clrn = 1'b1;
      tick();
      checks++; if (cnt_q_l !== 8'h01) begin errors++; $display("FAIL ind_resume got %h want 01", cnt_q_l); end
   endtask

   initial begin
      test_reset();
      test_count();
      test_counter_ctrl();
      test_left_fill();
      test_load_priority();
      test_right_shift();
      test_independence();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
